dly_ring_monitor: RTL and testbench



---
 rtl/dly_ring_monitor_pkg.sv | 24 ++
 rtl/dly_ring_monitor_sync.sv | 37 +++
 rtl/dly_ring_monitor.sv | 178 +++++++++++++++++
 tb/tb_dly_ring_monitor.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dly_ring_monitor_pkg.sv
// dly_ring_monitor_pkg: shared types and default constants for the
// delay-chain ring-oscillator monitor.
package dly_ring_monitor_pkg;

  // Measurement sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    REPORT  = 2'd3
  } state_t;

  // Default widths and timing.
  localparam int CNT_W_DEF       = 16;
  localparam int WIN_W_DEF       = 16;
  localparam int SETTLE_CYC_DEF  = 8;
  localparam int SYNC_STAGES_DEF = 2;

  // Bits needed for a timer that counts 0 .. n-1 (never less than one bit).
  function automatic int timer_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dly_ring_monitor_sync.sv
// dly_ring_monitor_sync: brings the asynchronous (pre-divided) ring output
// into the CLK domain through a SYNC_STAGES-deep flop chain and flags each
// synchronized rising edge with a one-cycle pulse. Legal SYNC_STAGES: 2..4.
module dly_ring_monitor_sync
  import dly_ring_monitor_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic RO_IN,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   sync_out_d;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Shift RO_IN through the synchronizer and keep a delayed copy of its output.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q     <= '0;
      sync_out_d <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], RO_IN};
      sync_out_d <= sync_out;
    end
  end

  // Both operands are flop outputs, so the pulse is glitch-free and lasts one
  // cycle. Each synchronized low-to-high transition gives exactly one pulse;
  // inputs faster than CLK/4 will lose edges inside the synchronizer.
  assign rise_pulse = sync_out & ~sync_out_d;

endmodule

// File: rtl/dly_ring_monitor.sv
// dly_ring_monitor: enables an external delay-cell ring oscillator, lets it
// settle, counts synchronized rising edges over a programmable CLK window and
// reports the saturating count.
// Build option: DLY_RING_MONITOR_CONT_EN adds the CONT input, which chains
// measurement windows back to back without re-settling the ring.
module dly_ring_monitor
  import dly_ring_monitor_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int WIN_W       = WIN_W_DEF,
  parameter int SETTLE_CYC  = SETTLE_CYC_DEF,   // must be >= SYNC_STAGES+1
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIN_W-1:0] WINDOW,
  input  logic             RO_IN,
`ifdef DLY_RING_MONITOR_CONT_EN
  input  logic             CONT,
`endif
  output logic             RO_EN,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] COUNT,
  output logic             OVF,
  output state_t           dbg_state
);

  // Request/response protocol: START is a request that is accepted only on a
  // CLK edge where BUSY is low (state IDLE); WINDOW is captured on that same
  // edge. There is no back-pressure and no queuing: START while BUSY is
  // dropped. DONE is a single-cycle response; COUNT/OVF are valid from the
  // DONE cycle and held until the next DONE.

  localparam int              ST_W        = timer_w(SETTLE_CYC);
  localparam logic [ST_W-1:0] SETTLE_LAST = ST_W'(SETTLE_CYC - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] win_cnt;
  logic [WIN_W-1:0] win_last;
  logic [ST_W-1:0]  settle_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             ovf_q;
  logic             rise;
  logic             settle_done;
  logic             win_done;
  logic             win_zero;
  logic             cont_go;

  dly_ring_monitor_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .CLK        (CLK),
    .RST        (RST),
    .RO_IN      (RO_IN),
    .rise_pulse (rise)
  );

  assign win_zero    = (win_q == '0);
  assign win_last    = win_q - WIN_W'(1);
  assign settle_done = (settle_cnt == SETTLE_LAST);
  assign win_done    = (win_cnt == win_last);

`ifdef DLY_RING_MONITOR_CONT_EN
  // A zero-length window cannot be repeated, so it falls back to single-shot.
  assign cont_go = CONT & ~win_zero;
`else
  assign cont_go = 1'b0;
`endif

  assign BUSY      = (state_q != IDLE);
  assign dbg_state = state_q;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_done) begin
          state_d = win_zero ? REPORT : MEASURE;
        end
      end
      MEASURE: begin
        if (win_done) begin
          state_d = REPORT;
        end
      end
      REPORT: begin
        state_d = cont_go ? MEASURE : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Timers, edge counter, ring enable and the registered result outputs.
  // DONE/COUNT/OVF are loaded on the edge that leaves REPORT, so the result
  // is already stable in the cycle DONE is high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      win_q      <= '0;
      win_cnt    <= '0;
      settle_cnt <= '0;
      edge_cnt   <= '0;
      ovf_q      <= 1'b0;
      RO_EN      <= 1'b0;
      DONE       <= 1'b0;
      COUNT      <= '0;
      OVF        <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state_q)
        IDLE: begin
          if (START) begin
            win_q      <= WINDOW;
            settle_cnt <= '0;
            RO_EN      <= 1'b1;
          end
        end
        SETTLE: begin
          // Ring runs but edges are ignored while it settles and while the
          // synchronizer flushes stale samples.
          settle_cnt <= settle_cnt + ST_W'(1);
          if (settle_done) begin
            edge_cnt <= '0;
            ovf_q    <= 1'b0;
            win_cnt  <= '0;
          end
        end
        MEASURE: begin
          win_cnt <= win_cnt + WIN_W'(1);
          if (rise) begin
            if (&edge_cnt) begin
              ovf_q <= 1'b1;
            end else begin
              edge_cnt <= edge_cnt + CNT_W'(1);
            end
          end
        end
        REPORT: begin
          DONE  <= 1'b1;
          COUNT <= edge_cnt;
          OVF   <= ovf_q;
          if (cont_go) begin
            // Next window starts immediately with the ring left running.
            edge_cnt <= '0;
            ovf_q    <= 1'b0;
            win_cnt  <= '0;
          end else begin
            RO_EN <= 1'b0;
          end
        end
        default: begin
          RO_EN <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dly_ring_monitor.sv
// tb_dly_ring_monitor: randomized self-checking bench for dly_ring_monitor.
// Reference model: every rising edge driven onto RO_IN is logged with its
// cycle index; an edge is expected in a window when it reaches the edge
// detector (SYNC+1 clocks later) during one of the window's CLK cycles.
`timescale 1ns/1ps
module tb_dly_ring_monitor;
  import dly_ring_monitor_pkg::*;

  localparam int CNT_W  = 16;
  localparam int WIN_W  = 16;
  localparam int SETTLE = 8;
  localparam int SYNC   = 2;
  localparam int SAT_W  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             start   = 1'b0;
  logic             start_s = 1'b0;
  logic [WIN_W-1:0] window  = '0;
  logic             ro_in   = 1'b0;
  logic             cont    = 1'b0;

  logic             ro_en, busy, done, ovf;
  logic [CNT_W-1:0] count;
  state_t           st;
  logic             ro_en_s, busy_s, done_s, ovf_s;
  logic [SAT_W-1:0] count_s;
  state_t           st_s;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ro_period = 0;
  int ro_ph     = 0;
  logic ro_nxt;
  int rise_q[$];
  logic [CNT_W-1:0] exp_q[$];

  dly_ring_monitor #(
    .CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE_CYC(SETTLE), .SYNC_STAGES(SYNC)
  ) u_dut (
    .CLK(clk), .RST(rst), .START(start), .WINDOW(window), .RO_IN(ro_in),
`ifdef DLY_RING_MONITOR_CONT_EN
    .CONT(cont),
`endif
    .RO_EN(ro_en), .BUSY(busy), .DONE(done), .COUNT(count), .OVF(ovf),
    .dbg_state(st)
  );

  dly_ring_monitor #(
    .CNT_W(SAT_W), .WIN_W(WIN_W), .SETTLE_CYC(SETTLE), .SYNC_STAGES(SYNC)
  ) u_sat (
    .CLK(clk), .RST(rst), .START(start_s), .WINDOW(window), .RO_IN(ro_in),
`ifdef DLY_RING_MONITOR_CONT_EN
    .CONT(1'b0),
`endif
    .RO_EN(ro_en_s), .BUSY(busy_s), .DONE(done_s), .COUNT(count_s), .OVF(ovf_s),
    .dbg_state(st_s)
  );

  // Cycle index: after edge k (sampled #1 later) cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  // Ring stimulus: square wave of ro_period CLK cycles, rises logged.
  always @(posedge clk) begin
    #1;
    if (ro_period > 0) begin
      ro_nxt = (ro_ph < ro_period / 2);
      if (ro_nxt && !ro_in) rise_q.push_back(cyc);
      ro_in = ro_nxt;
      ro_ph = (ro_ph + 1) % ro_period;
    end else begin
      ro_in = 1'b0;
    end
  end

  // Watchdog.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Number of logged RO_IN rises driven in cycles lo..hi.
  function automatic int model_rises(input int lo, input int hi);
    int n;
    n = 0;
    foreach (rise_q[i]) if (rise_q[i] >= lo && rise_q[i] <= hi) n++;
    return n;
  endfunction

  // k-th window of a run accepted at edge a with window length w.
  function automatic int win_lo(input int a, input int w, input int k);
    return a + SETTLE - SYNC + k * (w + 1);
  endfunction

  // ---------------- driver ----------------
  task automatic run_one(input bit on_sat, input int w, input bit disturb,
                         output int a, output int done_at, output int en_bad,
                         output bit saw_meas, output logic [CNT_W-1:0] c_out,
                         output logic o_out, output logic done_after);
    logic d_v, e_v, b_v;
    state_t s_v;
    @(posedge clk); #1;
    window = WIN_W'(w);
    if (on_sat) start_s = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    a = cyc;
    start = 1'b0; start_s = 1'b0;
    done_at = -1; en_bad = 0; saw_meas = 1'b0; c_out = '0; o_out = 1'b0;
    for (int i = 0; i < w + SETTLE + 20; i++) begin
      d_v = on_sat ? done_s : done;
      e_v = on_sat ? ro_en_s : ro_en;
      b_v = on_sat ? busy_s : busy;
      s_v = on_sat ? st_s : st;
      if (e_v !== b_v) en_bad++;
      if (s_v == MEASURE) saw_meas = 1'b1;
      if (d_v === 1'b1) begin
        done_at = cyc;
        c_out = on_sat ? CNT_W'(count_s) : count;
        o_out = on_sat ? ovf_s : ovf;
        break;
      end
      if (disturb) begin
        start = (i == 3 || i == 50);
        if (i == 6) window = WIN_W'(10);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(posedge clk); #1;
    done_after = on_sat ? done_s : done;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ro_en, busy, done, ovf} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {ro_en, busy, done, ovf});
    end
    checks++;
    if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++;
    if (st !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", st, IDLE); end
    checks++;
    if ({ro_en_s, busy_s, done_s, ovf_s, count_s} !== 8'h00) begin
      errors++; $display("FAIL reset_sat: got %h expected 00", {ro_en_s, busy_s, done_s, ovf_s, count_s});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int a, dt, eb, exp_n;
    bit sm;
    logic [CNT_W-1:0] c;
    logic o, da;
    ro_period = 8;
    repeat (5) @(posedge clk);
    run_one(1'b0, 200, 1'b0, a, dt, eb, sm, c, o, da);
    exp_n = model_rises(win_lo(a, 200, 0), win_lo(a, 200, 0) + 199);
    checks++;
    if (dt !== a + SETTLE + 201) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", dt, a + SETTLE + 201); end
    checks++;
    if (c !== CNT_W'(exp_n)) begin errors++; $display("FAIL basic_count: got %0d expected %0d", c, exp_n); end
    checks++;
    if (o !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b expected 0", o); end
    checks++;
    if (eb != 0) begin errors++; $display("FAIL basic_ro_en: got %0d cycles with RO_EN!=BUSY expected 0", eb); end
    checks++;
    if (da !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got DONE=%b one cycle later expected 0", da); end
    checks++;
    if (ro_en !== 1'b0) begin errors++; $display("FAIL basic_ro_off: got %b expected 0", ro_en); end
  endtask

  task automatic test_zero_window();
    int a, dt, eb;
    bit sm;
    logic [CNT_W-1:0] c;
    logic o, da;
    run_one(1'b0, 0, 1'b0, a, dt, eb, sm, c, o, da);
    checks++;
    if (dt !== a + SETTLE + 1) begin errors++; $display("FAIL zero_latency: got %0d expected %0d", dt, a + SETTLE + 1); end
    checks++;
    if ({c, o} !== {CNT_W'(0), 1'b0}) begin errors++; $display("FAIL zero_result: got count %0d ovf %b expected 0 0", c, o); end
    checks++;
    if (sm !== 1'b0) begin errors++; $display("FAIL zero_no_measure: got visited=%b expected 0", sm); end
  endtask

  task automatic test_saturation();
    int a, dt, eb, n, w;
    bit sm;
    logic [CNT_W-1:0] c, ec;
    logic o, da, eo;
    ro_period = 4;
    for (int r = 0; r < 2; r++) begin
      w = (r == 0) ? 100 : 20;
      run_one(1'b1, w, 1'b0, a, dt, eb, sm, c, o, da);
      n = model_rises(win_lo(a, w, 0), win_lo(a, w, 0) + w - 1);
      ec = (n > 15) ? CNT_W'(15) : CNT_W'(n);
      eo = (n > 15);
      checks++;
      if (dt !== a + SETTLE + w + 1) begin errors++; $display("FAIL sat_latency_%0d: got %0d expected %0d", w, dt, a + SETTLE + w + 1); end
      checks++;
      if (c !== ec) begin errors++; $display("FAIL sat_count_%0d: got %0d expected %0d", w, c, ec); end
      checks++;
      if (o !== eo) begin errors++; $display("FAIL sat_ovf_%0d: got %b expected %b", w, o, eo); end
    end
  endtask

  task automatic test_busy_ignore();
    int a, dt, eb, n, extra;
    bit sm;
    logic [CNT_W-1:0] c;
    logic o, da;
    ro_period = 2 * $urandom_range(2, 6);
    repeat (3) @(posedge clk);
    run_one(1'b0, 100, 1'b1, a, dt, eb, sm, c, o, da);
    n = model_rises(win_lo(a, 100, 0), win_lo(a, 100, 0) + 99);
    checks++;
    if (dt !== a + SETTLE + 101) begin errors++; $display("FAIL busy_latency: got %0d expected %0d", dt, a + SETTLE + 101); end
    checks++;
    if (c !== CNT_W'(n)) begin errors++; $display("FAIL busy_count: got %0d expected %0d", c, n); end
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL busy_no_requeue: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_back_to_back();
    int a, a2, w, d1, d2, n1, n2;
    logic [CNT_W-1:0] c1, c2;
    ro_period = $urandom_range(4, 11);
    w = $urandom_range(5, 30);
    d1 = -1; d2 = -1; c1 = '0; c2 = '0;
    @(posedge clk); #1;
    window = WIN_W'(w);
    start = 1'b1;
    @(posedge clk); #1;
    a = cyc;
    for (int i = 0; i < 2 * (SETTLE + w) + 40 && d2 < 0; i++) begin
      @(posedge clk); #1;
      if (d1 >= 0 && cyc == d1 + 1) start = 1'b0;
      if (done === 1'b1) begin
        if (d1 < 0) begin d1 = cyc; c1 = count; end
        else begin d2 = cyc; c2 = count; end
      end
    end
    start = 1'b0;
    a2 = a + SETTLE + w + 2;
    n1 = model_rises(win_lo(a, w, 0), win_lo(a, w, 0) + w - 1);
    n2 = model_rises(win_lo(a2, w, 0), win_lo(a2, w, 0) + w - 1);
    checks++;
    if (d1 !== a + SETTLE + w + 1) begin errors++; $display("FAIL b2b_done1: got %0d expected %0d", d1, a + SETTLE + w + 1); end
    checks++;
    if (d2 !== a2 + SETTLE + w + 1) begin errors++; $display("FAIL b2b_done2: got %0d expected %0d", d2, a2 + SETTLE + w + 1); end
    checks++;
    if ({c1, c2} !== {CNT_W'(n1), CNT_W'(n2)}) begin
      errors++; $display("FAIL b2b_counts: got %0d,%0d expected %0d,%0d", c1, c2, n1, n2);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_random();
    int a, dt, eb, w, n;
    bit sm;
    logic [CNT_W-1:0] c, e;
    logic o, da;
    for (int r = 0; r < 6; r++) begin
      ro_period = $urandom_range(4, 16);
      ro_ph = 0;
      w = $urandom_range(1, 150);
      repeat ($urandom_range(1, 7)) @(posedge clk);
      run_one(1'b0, w, 1'b0, a, dt, eb, sm, c, o, da);
      n = model_rises(win_lo(a, w, 0), win_lo(a, w, 0) + w - 1);
      exp_q.push_back(CNT_W'(n));
      e = exp_q.pop_front();
      checks++;
      if (dt !== a + SETTLE + w + 1) begin errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", r, dt, a + SETTLE + w + 1); end
      checks++;
      if ({c, o} !== {e, 1'b0}) begin errors++; $display("FAIL rand%0d_count: got %0d ovf %b expected %0d ovf 0", r, c, o, e); end
    end
  endtask

  task automatic test_reset_mid();
    int a, dt, eb, n, late;
    bit sm;
    logic [CNT_W-1:0] c;
    logic o, da;
    ro_period = 6;
    @(posedge clk); #1;
    window = WIN_W'(150);
    start = 1'b1;
    @(posedge clk); #1;
    a = cyc;
    start = 1'b0;
    repeat (SETTLE + 40) @(posedge clk);
    #1;
    checks++;
    if (st !== MEASURE) begin errors++; $display("FAIL rstmid_pre_state: got %0d expected %0d", st, MEASURE); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ro_en, busy, done} !== 3'b000) begin errors++; $display("FAIL rstmid_flags: got %b expected 000", {ro_en, busy, done}); end
    checks++;
    if (count !== '0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", count); end
    rst = 1'b0;
    late = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (done === 1'b1 || ro_en === 1'b1) late++;
    end
    checks++;
    if (late != 0) begin errors++; $display("FAIL rstmid_quiet: got %0d active cycles expected 0", late); end
    run_one(1'b0, 60, 1'b0, a, dt, eb, sm, c, o, da);
    n = model_rises(win_lo(a, 60, 0), win_lo(a, 60, 0) + 59);
    checks++;
    if (dt !== a + SETTLE + 61) begin errors++; $display("FAIL rstmid_rerun_latency: got %0d expected %0d", dt, a + SETTLE + 61); end
    checks++;
    if (c !== CNT_W'(n)) begin errors++; $display("FAIL rstmid_rerun_count: got %0d expected %0d", c, n); end
  endtask

`ifdef DLY_RING_MONITOR_CONT_EN
  task automatic test_cont();
    int a, w, k, n, lo, extra;
    w = 50;
    k = 0;
    ro_period = 5;
    cont = 1'b1;
    @(posedge clk); #1;
    window = WIN_W'(w);
    start = 1'b1;
    @(posedge clk); #1;
    a = cyc;
    start = 1'b0;
    for (int i = 0; i < SETTLE + 5 * (w + 1) + 20 && k < 4; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lo = win_lo(a, w, k);
        n = model_rises(lo, lo + w - 1);
        checks++;
        if (cyc != a + SETTLE + w + 1 + k * (w + 1)) begin
          errors++; $display("FAIL cont_done%0d_time: got %0d expected %0d", k, cyc, a + SETTLE + w + 1 + k * (w + 1));
        end
        checks++;
        if (count !== CNT_W'(n)) begin errors++; $display("FAIL cont_done%0d_count: got %0d expected %0d", k, count, n); end
        k++;
        if (k == 3) cont = 1'b0;
      end
    end
    checks++;
    if (k != 4) begin errors++; $display("FAIL cont_done_total: got %0d expected 4", k); end
    checks++;
    if ({ro_en, st} !== {1'b0, IDLE}) begin errors++; $display("FAIL cont_exit: got ro_en %b state %0d expected 0 %0d", ro_en, st, IDLE); end
    extra = 0;
    repeat (w + 20) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL cont_no_more_done: got %0d expected 0", extra); end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_zero_window();
    test_saturation();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef DLY_RING_MONITOR_CONT_EN
    test_cont();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
